// File: rtl/fifo_reader_if.sv
// rtl/fifo_reader_if.sv - downstream byte stream between the FIFO drain engine and its consumer
interface fifo_reader_if #(
   parameter int DW = 8
);
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - read-domain FIFO drain engine feeding a stream through a 2-entry skid buffer
module fifo_reader #(
   parameter int DW    = 8,
   parameter int CNT_W = 16
) (
   input  logic             clkr,
   input  logic             rst,
   input  logic             e,
   input  logic [DW-1:0]    RD,
   output logic             RREQ,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             abort,
   fifo_reader_if.master    out_if,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] rd_count
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0] rd_count_q, rd_count_d;
   logic             rd_pend_q, rd_pend_d;
   logic [1:0]       occ_q, occ_d;
   logic [DW-1:0]    buf0_q, buf0_d;
   logic [DW-1:0]    buf1_q, buf1_d;
   logic             pop;
   logic             push;
   logic [2:0]       inflight;

   assign pop      = (occ_q != 2'd0) && out_if.out_ready;
   assign push     = rd_pend_q;
   // Buffered plus in-flight bytes after this cycle's pop; a new read needs a free slot.
   assign inflight = {1'b0, occ_q} + {2'b00, rd_pend_q} - {2'b00, pop};

   always_ff @(posedge clkr or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (len != '0) ? RUN : DONE;
         RUN:     if (remaining_q == '0 || abort) state_d = DRAIN;
         DRAIN:   if (occ_q == 2'd0 && !rd_pend_q) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == DONE);
      RREQ = (state_q == RUN) && !abort && !e && (remaining_q != '0) && (inflight <= 3'd1);
   end

   always_comb begin
      remaining_d = remaining_q;
      rd_count_d  = rd_count_q;
      rd_pend_d   = RREQ;
      occ_d       = occ_q;
      buf0_d      = buf0_q;
      buf1_d      = buf1_q;
      if (state_q == IDLE && start) begin
         remaining_d = len;
         rd_count_d  = '0;
      end else begin
         if (RREQ) remaining_d = remaining_q - 1'b1;
         if (pop && rd_count_q != '1) rd_count_d = rd_count_q + 1'b1;
      end
      if (push && !pop) begin
         if (occ_q == 2'd0) buf0_d = RD;
         else               buf1_d = RD;
         occ_d = occ_q + 2'd1;
      end else if (pop && !push) begin
         buf0_d = buf1_q;
         occ_d  = occ_q - 2'd1;
      end else if (push && pop) begin
         // Head leaves while the captured byte joins the tail.
         if (occ_q == 2'd1) begin
            buf0_d = RD;
         end else begin
            buf0_d = buf1_q;
            buf1_d = RD;
         end
      end
   end

   always_ff @(posedge clkr or negedge rst) begin
      if (!rst) begin
         remaining_q <= '0;
         rd_count_q  <= '0;
         rd_pend_q   <= 1'b0;
         occ_q       <= 2'd0;
         buf0_q      <= '0;
         buf1_q      <= '0;
      end else begin
         remaining_q <= remaining_d;
         rd_count_q  <= rd_count_d;
         rd_pend_q   <= rd_pend_d;
         occ_q       <= occ_d;
         buf0_q      <= buf0_d;
         buf1_q      <= buf1_d;
      end
   end

   assign out_if.out_data  = buf0_q;
   assign out_if.out_valid = (occ_q != 2'd0);
   assign rd_count         = rd_count_q;
endmodule
